// File: rtl/alloc_pkg.sv
// Shared types and helpers for the block allocator and its free-side counterpart.
// Latency: n/a (package only).
// Backpressure: n/a.
package alloc_pkg;

  localparam int NUM_BLOCKS       = 32;
  localparam int NUM_BLOCKS_WIDTH = $clog2(NUM_BLOCKS);

  // One bit wider than a block index so addr+size cannot overflow.
  typedef logic [NUM_BLOCKS_WIDTH:0] blk_ext_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } alloc_free_state_t;

  // Bits addr..addr+size-1 set; anything past the top block is dropped.
  function automatic logic [NUM_BLOCKS-1:0] range_mask(
    input logic [NUM_BLOCKS_WIDTH-1:0] addr,
    input logic [NUM_BLOCKS_WIDTH-1:0] size
  );
    blk_ext_t lo;
    blk_ext_t hi;
    range_mask = '0;
    lo = {1'b0, addr};
    hi = lo + {1'b0, size};
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      range_mask[i] = (blk_ext_t'(i) >= lo) && (blk_ext_t'(i) < hi);
    end
  endfunction

endpackage

// File: rtl/block_range_mask.sv
// Range-to-bitmask decoder with zero-size and upper-bound check.
// Latency: combinational.
// Backpressure: none.
// Ports: addr/size in -> mask (blocks addr..addr+size-1), in_range (size!=0 and addr+size<=N).
module block_range_mask #(
  parameter int N = alloc_pkg::NUM_BLOCKS,
  parameter int W = $clog2(N)
) (
  input  logic [W-1:0] addr,
  input  logic [W-1:0] size,
  output logic [N-1:0] mask,
  output logic         in_range
);
  import alloc_pkg::*;

  typedef logic [W:0] ext_t;

  ext_t lo;
  ext_t hi;

  always_comb begin
    lo       = {1'b0, addr};
    hi       = lo + {1'b0, size};
    in_range = (size != '0) && (hi <= ext_t'(N));
    mask     = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (ext_t'(i) >= lo) && (ext_t'(i) < hi);
    end
  end

endmodule

// File: rtl/block_free.sv
// Free-side walker: validates a free against a shadow ownership bitmap, then emits one clear per block.
// Latency: clears at T+1..T+size after en at edge T, o_done at T+size+1 (error: o_done at T+1).
// Backpressure: none; en is only sampled in IDLE, requests arriving while busy are dropped.
// Ports: clk/rst (async active-low); alloc_* grant records; en/free_* request;
//        o_clr_valid/o_clr_idx clear stream; o_done/o_err completion; o_busy; o_used_count popcount.
module block_free #(
  parameter int NUM_BLOCKS       = alloc_pkg::NUM_BLOCKS,
  parameter int NUM_BLOCKS_WIDTH = $clog2(NUM_BLOCKS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_valid,
  input  logic [NUM_BLOCKS_WIDTH-1:0] alloc_addr,
  input  logic [NUM_BLOCKS_WIDTH-1:0] alloc_size,
  input  logic                        en,
  input  logic [NUM_BLOCKS_WIDTH-1:0] free_addr,
  input  logic [NUM_BLOCKS_WIDTH-1:0] free_size,
  output logic                        o_clr_valid,
  output logic [NUM_BLOCKS_WIDTH-1:0] o_clr_idx,
  output logic                        o_done,
  output logic                        o_err,
  output logic                        o_busy,
  output logic [NUM_BLOCKS_WIDTH:0]   o_used_count
);
  import alloc_pkg::*;

  localparam int W = NUM_BLOCKS_WIDTH;
  typedef logic [W:0] cnt_t;

  alloc_free_state_t     state_q, state_d;
  logic [NUM_BLOCKS-1:0] shadow_q, shadow_d;
  logic [W-1:0]          cursor_q, cursor_d;
  logic [W-1:0]          remaining_q, remaining_d;
  logic                  fail_q, fail_d;
  logic                  clr_valid_q, clr_valid_d;
  logic [W-1:0]          clr_idx_q, clr_idx_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  cnt_t                  used_count_q, used_count_d;

  logic [NUM_BLOCKS-1:0] free_mask, alloc_mask;
  logic                  free_ok, alloc_ok;
  logic [NUM_BLOCKS-1:0] set_mask, clr_mask;

  block_range_mask #(.N(NUM_BLOCKS), .W(W)) u_free_rng (
    .addr     (free_addr),
    .size     (free_size),
    .mask     (free_mask),
    .in_range (free_ok)
  );

  block_range_mask #(.N(NUM_BLOCKS), .W(W)) u_alloc_rng (
    .addr     (alloc_addr),
    .size     (alloc_size),
    .mask     (alloc_mask),
    .in_range (alloc_ok)
  );

  always_comb begin
    state_d      = state_q;
    cursor_d     = cursor_q;
    remaining_d  = remaining_q;
    fail_d       = fail_q;
    clr_valid_d  = 1'b0;
    clr_idx_d    = '0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    clr_mask     = '0;
    set_mask     = (alloc_valid && alloc_ok) ? alloc_mask : '0;

    case (state_q)
      IDLE: begin
        if (en) begin
          // Any block in range not currently owned means a double or stray free.
          if (!free_ok || ((free_mask & ~shadow_q) != '0)) begin
            fail_d  = 1'b1;
            state_d = DONE;
          end else begin
            fail_d      = 1'b0;
            cursor_d    = free_addr;
            remaining_d = free_size;
            state_d     = CLEAR;
          end
        end
      end
      CLEAR: begin
        clr_valid_d        = 1'b1;
        clr_idx_d          = cursor_q;
        clr_mask[cursor_q] = 1'b1;
        if (remaining_q == W'(1)) begin
          // Cursor holds on the last block so a range ending at the top never wraps.
          remaining_d = '0;
          state_d     = DONE;
        end else begin
          cursor_d    = cursor_q + W'(1);
          remaining_d = remaining_q - W'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        err_d   = fail_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A grant landing on a block being cleared this edge keeps it owned.
    shadow_d = (shadow_q & ~clr_mask) | set_mask;
    busy_d   = (state_d != IDLE);

    used_count_d = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      used_count_d = used_count_d + cnt_t'(shadow_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      cursor_q     <= '0;
      remaining_q  <= '0;
      fail_q       <= 1'b0;
      clr_valid_q  <= 1'b0;
      clr_idx_q    <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      used_count_q <= '0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      cursor_q     <= cursor_d;
      remaining_q  <= remaining_d;
      fail_q       <= fail_d;
      clr_valid_q  <= clr_valid_d;
      clr_idx_q    <= clr_idx_d;
      done_q       <= done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      used_count_q <= used_count_d;
    end
  end

  assign o_clr_valid  = clr_valid_q;
  assign o_clr_idx    = clr_idx_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_busy       = busy_q;
  assign o_used_count = used_count_q;

endmodule

// File: doc/block_free.md
Name: block_free

Overview:
- Release-side counterpart of the block allocator: accepts free requests (start block, block count) and walks the range, emitting one bitmap-clear command per block.
- Keeps a shadow ownership bitmap, fed by the allocator's grant records, to reject double-frees, zero-size and out-of-range frees.
- Sits beside the allocator. The allocator's free bitmap consumes o_clr_valid/o_clr_idx.

Parameters:
- NUM_BLOCKS, 32, number of allocatable blocks (power of two, ≥4).
- NUM_BLOCKS_WIDTH, $clog2(NUM_BLOCKS), block index/size width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  allocator grant record valid (allocator's o_valid).
- alloc_addr  in  NUM_BLOCKS_WIDTH  granted start block.
- alloc_size  in  NUM_BLOCKS_WIDTH  granted block count.
- en  in  1  free request strobe, sampled only in IDLE.
- free_addr  in  NUM_BLOCKS_WIDTH  first block to free.
- free_size  in  NUM_BLOCKS_WIDTH  number of blocks to free.
- o_clr_valid  out  1  clear command valid this cycle.
- o_clr_idx  out  NUM_BLOCKS_WIDTH  block index to clear.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  one-cycle error pulse, coincident with o_done.
- o_busy  out  1  high while not IDLE.
- o_used_count  out  NUM_BLOCKS_WIDTH+1  popcount of shadow bitmap.

Behaviour:
- Reset (rst low, async): state IDLE, shadow bitmap all 0, cursor/remaining 0. All outputs 0.
- States: IDLE, CLEAR, DONE. All outputs registered.
- Range check (IDLE, en=1), in NUM_BLOCKS_WIDTH+1-bit arithmetic:
  - Build mask = ((1<<free_size)-1)<<free_addr.
  - err if free_size==0.
  - err if free_addr+free_size > NUM_BLOCKS.
  - err if (mask & ~shadow) != 0, i.e. any block in range not owned.
- IDLE, en=1, err: go to DONE. o_done=o_err=1 at T+1. No clears, bitmap untouched.
- IDLE, en=1, ok: latch cursor=free_addr and remaining=free_size, go to CLEAR.
- CLEAR: each cycle output o_clr_valid=1 with o_clr_idx=cursor, clear shadow[cursor], then cursor++ and remaining--. Go to DONE after the last block.
- Latency for en at edge T:
  - clears at T+1..T+free_size;
  - o_done at T+free_size+1;
  - IDLE at T+free_size+2.
- DONE: o_done pulse (o_err per check result), then IDLE. A new en is accepted on the cycle after DONE.
- en while o_busy: ignored, no queueing.
- Cursor never wraps: the range check guarantees free_addr+free_size ≤ NUM_BLOCKS.
- alloc_valid, any state: set shadow bits for range alloc_addr..alloc_addr+alloc_size-1, same edge.
  - Record with size 0 or exceeding NUM_BLOCKS is ignored.
  - Already-set bits stay set, no error.
- Same-bit set and clear on one edge: set wins. o_clr_valid is still emitted.
- o_used_count = popcount(shadow) registered, so it reflects the bitmap one edge after each update.
- Reset mid-CLEAR: immediate abort. The remaining clears are lost and the bitmap is zeroed.

Decomposition:
- Package alloc_pkg:
  - NUM_BLOCKS default;
  - state enum typedef alloc_free_state_t {IDLE, CLEAR, DONE};
  - function range_mask(addr, size) returning a NUM_BLOCKS-wide mask. The allocator uses the same function.
- Sub-module block_range_mask: combinational mask plus bounds/zero check, instantiated twice (free check, alloc record).

Test Plan:
- Reset, then alloc record (addr 4, size 3); one cycle later o_used_count=3. en free(4,3) → o_clr_idx 4,5,6 on three consecutive cycles, o_done=1 and o_err=0 the next cycle, o_used_count=0.
- free_size=0 → o_done=o_err=1 at T+1, no o_clr_valid, bitmap unchanged.
- Alloc (28,4) then free(30,4), sum 34>32 → error. Then free(28,4) → clears 28..31, cursor stops at 31, no wrap.
- Double free: alloc (0,2), free(0,2) succeeds, then free(0,2) again → o_err=1, zero clears.
- en pulsed during CLEAR of a 5-block free → ignored: exactly 5 clears and one o_done.
- rst low for one cycle during the 2nd clear of free(8,6) → outputs 0 immediately, o_used_count=0 after release, no further o_clr_valid.
